// File: rtl/mr_wb_arb.sv
// Writeback arbiter: ALU and LSU results each park in a one-entry holding register.
// The oldest held entry by issue tag drives the shared register-file write port.
module mr_wb_arb #(
  parameter int XLEN        = 32,
  parameter int REGSEL_BITS = 5,
  parameter int SEQ_BITS    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [REGSEL_BITS-1:0] a_reg,
  input  logic [XLEN-1:0]        a_val,
  input  logic [SEQ_BITS-1:0]    a_seq,
  input  logic                   a_jmp,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [REGSEL_BITS-1:0] m_reg,
  input  logic [XLEN-1:0]        m_val,
  input  logic [SEQ_BITS-1:0]    m_seq,
  output logic                   wb_valid,
  output logic [REGSEL_BITS-1:0] wb_reg,
  output logic [XLEN-1:0]        wb_val,
  output logic                   jmp_done
);

  logic                   ha_full_q, ha_full_d;
  logic [REGSEL_BITS-1:0] ha_reg_q,  ha_reg_d;
  logic [XLEN-1:0]        ha_val_q,  ha_val_d;
  logic [SEQ_BITS-1:0]    ha_seq_q,  ha_seq_d;
  logic                   ha_jmp_q,  ha_jmp_d;

  logic                   hm_full_q, hm_full_d;
  logic [REGSEL_BITS-1:0] hm_reg_q,  hm_reg_d;
  logic [XLEN-1:0]        hm_val_q,  hm_val_d;
  logic [SEQ_BITS-1:0]    hm_seq_q,  hm_seq_d;

  logic                   wb_valid_q, wb_valid_d;
  logic [REGSEL_BITS-1:0] wb_reg_q,   wb_reg_d;
  logic [XLEN-1:0]        wb_val_q,   wb_val_d;
  logic                   jmp_done_q, jmp_done_d;

  logic                   grant_a;
  logic                   grant_m;
  logic [SEQ_BITS-1:0]    seq_diff;
  logic                   a_fire;
  logic                   m_fire;

  // Modular tag difference: MSB set means HA was issued before HM.
  always_comb begin
    seq_diff = ha_seq_q - hm_seq_q;
    grant_a  = ha_full_q & (~hm_full_q | seq_diff[SEQ_BITS-1]);
    grant_m  = hm_full_q & ~grant_a;
  end

  // Ready looks at this cycle's grant so a draining entry can be refilled at once.
  always_comb begin
    a_ready = ~rst & (~ha_full_q | grant_a);
    m_ready = ~rst & (~hm_full_q | grant_m);
    a_fire  = a_valid & a_ready;
    m_fire  = m_valid & m_ready;
  end

  always_comb begin
    ha_full_d = ha_full_q;
    ha_reg_d  = ha_reg_q;
    ha_val_d  = ha_val_q;
    ha_seq_d  = ha_seq_q;
    ha_jmp_d  = ha_jmp_q;
    if (a_fire) begin
      ha_full_d = 1'b1;
      ha_reg_d  = a_reg;
      ha_val_d  = a_val;
      ha_seq_d  = a_seq;
      ha_jmp_d  = a_jmp;
    end else if (grant_a) begin
      ha_full_d = 1'b0;
    end
  end

  always_comb begin
    hm_full_d = hm_full_q;
    hm_reg_d  = hm_reg_q;
    hm_val_d  = hm_val_q;
    hm_seq_d  = hm_seq_q;
    if (m_fire) begin
      hm_full_d = 1'b1;
      hm_reg_d  = m_reg;
      hm_val_d  = m_val;
      hm_seq_d  = m_seq;
    end else if (grant_m) begin
      hm_full_d = 1'b0;
    end
  end

  // Register and data hold their last value when nothing is granted.
  always_comb begin
    wb_valid_d = grant_a | grant_m;
    jmp_done_d = grant_a & ha_jmp_q;
    wb_reg_d   = wb_reg_q;
    wb_val_d   = wb_val_q;
    if (grant_a) begin
      wb_reg_d = ha_reg_q;
      wb_val_d = ha_val_q;
    end else if (grant_m) begin
      wb_reg_d = hm_reg_q;
      wb_val_d = hm_val_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ha_full_q  <= 1'b0;
      ha_reg_q   <= '0;
      ha_val_q   <= '0;
      ha_seq_q   <= '0;
      ha_jmp_q   <= 1'b0;
      hm_full_q  <= 1'b0;
      hm_reg_q   <= '0;
      hm_val_q   <= '0;
      hm_seq_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_val_q   <= '0;
      jmp_done_q <= 1'b0;
    end else begin
      ha_full_q  <= ha_full_d;
      ha_reg_q   <= ha_reg_d;
      ha_val_q   <= ha_val_d;
      ha_seq_q   <= ha_seq_d;
      ha_jmp_q   <= ha_jmp_d;
      hm_full_q  <= hm_full_d;
      hm_reg_q   <= hm_reg_d;
      hm_val_q   <= hm_val_d;
      hm_seq_q   <= hm_seq_d;
      wb_valid_q <= wb_valid_d;
      wb_reg_q   <= wb_reg_d;
      wb_val_q   <= wb_val_d;
      jmp_done_q <= jmp_done_d;
    end
  end

  always_comb begin
    wb_valid = wb_valid_q;
    wb_reg   = wb_reg_q;
    wb_val   = wb_val_q;
    jmp_done = jmp_done_q;
  end

  // Equal tags in both entries mean the issue stage broke its tag discipline.
  assert property (@(posedge clk) disable iff (rst)
    !(ha_full_q && hm_full_q && (ha_seq_q == hm_seq_q)));

endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed bench for mr_wb_arb: a per-cycle vector table plus reset and streaming sequences.
module tb_mr_wb_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_jmp;
  logic [4:0]  a_reg;
  logic [31:0] a_val;
  logic [2:0]  a_seq;
  logic        m_valid, m_ready;
  logic [4:0]  m_reg;
  logic [31:0] m_val;
  logic [2:0]  m_seq;
  logic        wb_valid, jmp_done;
  logic [4:0]  wb_reg;
  logic [31:0] wb_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mr_wb_arb #(.XLEN(32), .REGSEL_BITS(5), .SEQ_BITS(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_val(a_val),
    .a_seq(a_seq), .a_jmp(a_jmp),
    .m_valid(m_valid), .m_ready(m_ready), .m_reg(m_reg), .m_val(m_val),
    .m_seq(m_seq),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val), .jmp_done(jmp_done)
  );

  typedef struct packed {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] aval;
    logic [2:0]  as;
    logic        aj;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] mval;
    logic [2:0]  ms;
    logic        ear;
    logic        emr;
    logic        ewv;
    logic [4:0]  ewr;
    logic [31:0] ewval;
    logic        ej;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_a(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic [2:0] s, input logic j);
    a_valid = v; a_reg = r; a_val = d; a_seq = s; a_jmp = j;
  endtask

  task automatic drive_m(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic [2:0] s);
    m_valid = v; m_reg = r; m_val = d; m_seq = s;
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: a{v,reg,val,seq,jmp} m{v,reg,val,seq} | a_ready m_ready | wb{valid,reg,val} jmp_done
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b0,5'd0,32'h0,1'b0});
    vq.push_back('{1'b1,5'd5,32'hDEADBEEF,3'd1,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b0,5'd0,32'h0,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b1,5'd5,32'hDEADBEEF,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b0,5'd5,32'hDEADBEEF,1'b0});
    // Same destination: older LSU entry (seq 2) must retire before ALU (seq 3)
    vq.push_back('{1'b1,5'd7,32'h22,3'd3,1'b0, 1'b1,5'd7,32'h11,3'd2, 1'b1,1'b1, 1'b0,5'd5,32'hDEADBEEF,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b0,1'b1, 1'b1,5'd7,32'h11,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b1,5'd7,32'h22,1'b0});
    // Tag wrap: HA seq 7 is older than HM seq 0
    vq.push_back('{1'b1,5'd3,32'hA7,3'd7,1'b0, 1'b1,5'd4,32'hB0,3'd0, 1'b1,1'b1, 1'b0,5'd7,32'h22,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b0, 1'b1,5'd3,32'hA7,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b1,5'd4,32'hB0,1'b0});
    // Jump to r0
    vq.push_back('{1'b1,5'd0,32'h1234,3'd1,1'b1, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b0,5'd4,32'hB0,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b1,5'd0,32'h1234,1'b1});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b0,5'd0,32'h1234,1'b0});
    // Drain-and-refill in one cycle on both sides
    vq.push_back('{1'b1,5'd1,32'h100,3'd2,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b0,5'd0,32'h1234,1'b0});
    vq.push_back('{1'b1,5'd2,32'h200,3'd3,1'b0, 1'b1,5'd6,32'h600,3'd4, 1'b1,1'b1, 1'b1,5'd1,32'h100,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b0, 1'b1,5'd2,32'h200,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b1,5'd9,32'h900,3'd5, 1'b1,1'b1, 1'b1,5'd6,32'h600,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b1,5'd9,32'h900,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b0,5'd9,32'h900,1'b0});
    // Losing ALU entry refuses a new request and keeps its contents
    vq.push_back('{1'b1,5'd1,32'h11,3'd6,1'b0, 1'b1,5'd2,32'h22,3'd5, 1'b1,1'b1, 1'b0,5'd9,32'h900,1'b0});
    vq.push_back('{1'b1,5'd4,32'h44,3'd0,1'b0, 1'b1,5'd3,32'h33,3'd7, 1'b0,1'b1, 1'b1,5'd2,32'h22,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b0, 1'b1,5'd1,32'h11,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b1,5'd3,32'h33,1'b0});
    vq.push_back('{1'b0,5'd0,32'h0,3'd0,1'b0, 1'b0,5'd0,32'h0,3'd0, 1'b1,1'b1, 1'b0,5'd3,32'h33,1'b0});

    // Reset held 2 cycles with both sources requesting
    rst = 1'b1;
    drive_a(1'b1, 5'd12, 32'hCAFE, 3'd2, 1'b1);
    drive_m(1'b1, 5'd13, 32'hBEEF, 3'd3);
    for (int i = 0; i < 2; i++) begin
      step_edge();
      chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
      chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_jmp_done", {31'd0, jmp_done}, 32'd0);
      chk("rst_wb_reg", {27'd0, wb_reg}, 32'd0);
      chk("rst_wb_val", wb_val, 32'd0);
    end
    rst = 1'b0;
    drive_a(1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
    drive_m(1'b0, 5'd0, 32'h0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step_edge();
      chk("post_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("post_rst_jmp_done", {31'd0, jmp_done}, 32'd0);
    end

    foreach (vq[k]) begin
      drive_a(vq[k].av, vq[k].ar, vq[k].aval, vq[k].as, vq[k].aj);
      drive_m(vq[k].mv, vq[k].mr, vq[k].mval, vq[k].ms);
      #1;
      chk($sformatf("v%0d_a_ready", k), {31'd0, a_ready}, {31'd0, vq[k].ear});
      chk($sformatf("v%0d_m_ready", k), {31'd0, m_ready}, {31'd0, vq[k].emr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wb_valid", k), {31'd0, wb_valid}, {31'd0, vq[k].ewv});
      chk($sformatf("v%0d_wb_reg", k), {27'd0, wb_reg}, {27'd0, vq[k].ewr});
      chk($sformatf("v%0d_wb_val", k), wb_val, vq[k].ewval);
      chk($sformatf("v%0d_jmp_done", k), {31'd0, jmp_done}, {31'd0, vq[k].ej});
      $display("[TB] vector %0d: wb_valid=%0b wb_reg=%0d wb_val=0x%0h jmp_done=%0b",
               k, wb_valid, wb_reg, wb_val, jmp_done);
    end

    // Back-to-back ALU streaming: 8 requests, 8 consecutive writebacks one edge later
    drive_m(1'b0, 5'd0, 32'h0, 3'd0);
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) drive_a(1'b1, 5'(i + 10), 32'h5000 + 32'(i), 3'(i), 1'b0);
      else       drive_a(1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
      #1;
      if (i < 8) chk($sformatf("stream%0d_a_ready", i), {31'd0, a_ready}, 32'd1);
      @(posedge clk);
      #1;
      if (i >= 1) begin
        chk($sformatf("stream%0d_wb_valid", i), {31'd0, wb_valid}, 32'd1);
        chk($sformatf("stream%0d_wb_reg", i), {27'd0, wb_reg}, 32'(i + 9));
        chk($sformatf("stream%0d_wb_val", i), wb_val, 32'h5000 + 32'(i - 1));
        $display("[TB] stream %0d: wb_reg=%0d wb_val=0x%0h", i, wb_reg, wb_val);
      end
    end
    step_edge();
    chk("stream_end_wb_valid", {31'd0, wb_valid}, 32'd0);

    // Reset while an ALU entry is held discards it
    drive_a(1'b1, 5'd21, 32'h55, 3'd1, 1'b1);
    step_edge();
    drive_a(1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
    rst = 1'b1;
    step_edge();
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("midrst_jmp_done", {31'd0, jmp_done}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step_edge();
      chk("midrst_after_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("midrst_after_wb_reg", {27'd0, wb_reg}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mr_wb_arb.md
# mr_wb_arb

Writeback arbiter that shares the single register-file write port of the decode stage (`wb_valid`/`wb_reg`/`wb_val`/`jmp_done`) between two result producers: the ALU/branch path and the load/store unit.

- Each source has a one-entry holding register.
- Grants go strictly oldest-first, by issue sequence number, so writes to the same register retire in program order.
- The winner is registered onto the writeback outputs.

## Interface

Parameters:

- `XLEN`, 32, data width.
- `REGSEL_BITS`, 5, register select width.
- `SEQ_BITS`, 3, issue sequence tag width. In-flight tag spread must stay below 2^(SEQ_BITS-1).

Ports:

- `clk`  in  1  clock. Single clock domain, rising edge only.
- `rst`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  ALU-path result request.
- `a_ready`  out  1  ALU-path request accepted this cycle.
- `a_reg`  in  REGSEL_BITS  destination register (0 means no write).
- `a_val`  in  XLEN  result data.
- `a_seq`  in  SEQ_BITS  issue sequence tag.
- `a_jmp`  in  1  result belongs to a control-transfer instruction.
- `m_valid`  in  1  LSU result request.
- `m_ready`  out  1  LSU request accepted this cycle.
- `m_reg`  in  REGSEL_BITS  destination register.
- `m_val`  in  XLEN  load data (stores present `m_reg`=0).
- `m_seq`  in  SEQ_BITS  issue sequence tag.
- `wb_valid`  out  1  registered writeback strobe.
- `wb_reg`  out  REGSEL_BITS  registered writeback register.
- `wb_val`  out  XLEN  registered writeback data.
- `jmp_done`  out  1  registered one-cycle pulse: a jump has resolved.

## Operation

Holding registers:

- Holding registers `HA` and `HM` each store {full, reg, val, seq}; `HA` also stores jmp.
- A source transfers when valid & ready are both high at a rising edge.

Ready rules:

- `a_ready` = !rst & (!HA.full | grant_a).
- `m_ready` = !rst & (!HM.full | grant_m).
- Ready depends combinationally on this cycle's grant, so a drain and a refill happen in the same cycle.

Arbitration (combinational, on holding registers only):

- Only `HA` full: grant_a.
- Only `HM` full: grant_m.
- Both full: compute d = (HA.seq − HM.seq) mod 2^SEQ_BITS.
  - d MSB set: `HA` is older, grant_a.
  - Otherwise grant_m.
- HA.seq == HM.seq while both are full is illegal. Simulation asserts on it; hardware grants `HM`.
- At most one grant per cycle.

Writeback (registered):

- On a granted cycle, capture at the next edge:
  - `wb_valid`=1.
  - `wb_reg`/`wb_val` from the winner.
  - `jmp_done` = grant_a & HA.jmp.
- Register 0 results still produce `wb_valid`=1 with `wb_reg`=0; the consumer ignores them.
- A jump with `a_reg`=0 still pulses `jmp_done`.
- On cycles with no grant, `wb_valid` and `jmp_done` are 0. `wb_reg`/`wb_val` hold their last values.

Entry lifetime:

- A granted entry's full bit clears at the same edge its writeback is captured, unless the source refills it in that cycle.
- A losing entry keeps its contents unchanged.

## Timing

Reset values (rst high at an edge):

- `HA`/`HM` empty; `wb_valid`=0, `jmp_done`=0, `wb_reg`=0, `wb_val`=0.
- `a_ready`=`m_ready`=0 while rst is high.
- Reset mid-operation discards both held entries and any un-captured grant. The pending-write bookkeeping in decode is reset by the same rst.

Latency and throughput:

- Request accepted at edge E0, entry held after E0.
- If uncontested, it is granted in the following cycle and `wb_*` are visible after edge E1 (1 cycle from hold, 2 edges from request).
- Throughput: one writeback per cycle in aggregate. Each source sustains one per cycle while the other is idle.
- A loser is delayed one cycle per older competing entry.

Fairness:

- No starvation. Tags are issue-monotonic, so a waiting entry becomes the oldest within bounded time.

## Test plan

- Reset: assert rst for 2 cycles with `a_valid`=`m_valid`=1. Required: readies 0, `wb_valid` 0, `jmp_done` 0, nothing retires after rst drops except newly accepted requests.
- Single ALU write: `a_reg`=5, `a_val`=0xDEADBEEF, `a_seq`=1 at E0. Required: `wb_valid`=1, `wb_reg`=5, `wb_val`=0xDEADBEEF after E1 only; `jmp_done`=0.
- Ordering: `HM` {reg 7, val 0x11, seq 2} and `HA` {reg 7, val 0x22, seq 3} full simultaneously. Required: reg 7/0x11 retires first, then reg 7/0x22 on the next cycle.
- Tag wrap: `HA`.seq=7, `HM`.seq=0 (SEQ_BITS=3). Required: `HA` wins (d=7, MSB set).
- Jump with rd=0: `a_jmp`=1, `a_reg`=0. Required: one-cycle `jmp_done`=1 coincident with `wb_valid`=1, `wb_reg`=0.
- Back-to-back streaming: `a_valid` held high for 8 cycles with `m_valid`=0. Required: `a_ready` stays 1 and 8 consecutive `wb_valid` pulses.
